// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control unit.
// The immediate, ALU and mux encodings here must match the datapath decoders.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR1,
        S_JALR2,
        S_LUI
    } state_t;

    localparam state_t RESET_STATE = S_FETCH;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_DATA   = 2'b01,
        RES_ALU    = 2'b10,
        RES_PC     = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    // ALU operation class handed to the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    // Per-state Moore outputs plus the qualifiers for the few
    // outputs that also depend on live inputs.
    typedef struct packed {
        logic        adr_src;
        logic        mem_write;
        logic        reg_write;
        logic        pc_write;
        logic        fetch;
        logic        branch;
        result_src_e result_src;
        alu_src_a_e  alu_src_a;
        alu_src_b_e  alu_src_b;
        imm_src_e    imm_src;
        alu_op_e     alu_op;
        logic        is_rtype;
    } ctrl_out_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: is_legal_op = 1'b1;
            default:                            is_legal_op = 1'b0;
        endcase
    endfunction

    // op only matters in MEMADR, where it selects S vs I immediates.
    function automatic ctrl_out_t state_outputs(input state_t s, input logic [6:0] op);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.fetch      = 1'b1;
                o.result_src = RES_ALU;
                o.alu_src_b  = SRCB_FOUR;
            end
            S_DECODE: begin
                o.alu_src_a = SRCA_OLDPC;
                o.alu_src_b = SRCB_IMM;
                o.imm_src   = IMM_B;
            end
            S_MEMADR: begin
                o.alu_src_a = SRCA_RS1;
                o.alu_src_b = SRCB_IMM;
                o.imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: o.adr_src = 1'b1;
            S_MEMWB: begin
                o.result_src = RES_DATA;
                o.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                o.adr_src   = 1'b1;
                o.mem_write = 1'b1;
            end
            S_EXECR: begin
                o.alu_src_a = SRCA_RS1;
                o.alu_src_b = SRCB_RS2;
                o.alu_op    = ALUOP_FUNCT;
                o.is_rtype  = 1'b1;
            end
            S_EXECI: begin
                o.alu_src_a = SRCA_RS1;
                o.alu_src_b = SRCB_IMM;
                o.imm_src   = IMM_I;
                o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: o.reg_write = 1'b1;
            S_BRANCH: begin
                o.alu_src_a = SRCA_RS1;
                o.alu_src_b = SRCB_RS2;
                o.alu_op    = ALUOP_SUB;
                o.branch    = 1'b1;
            end
            S_JAL: begin
                o.pc_write  = 1'b1;
                o.alu_src_a = SRCA_OLDPC;
                o.alu_src_b = SRCB_FOUR;
                o.imm_src   = IMM_J;
            end
            S_JALR1: begin
                o.result_src = RES_PC;
                o.reg_write  = 1'b1;
                o.alu_src_a  = SRCA_RS1;
                o.alu_src_b  = SRCB_IMM;
                o.imm_src    = IMM_I;
            end
            S_JALR2: o.pc_write = 1'b1;
            S_LUI: begin
                o.imm_src   = IMM_U;
                o.alu_src_a = SRCA_RS1;
                o.alu_src_b = SRCB_IMM;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, selects and enables out.
// state is a debug view of the FSM for the datapath/trace side.
interface multicycle_ctrl_if;
    import ctrl_pkg::*;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       neg;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [2:0] imm_src;
    logic       reg_write;
    logic       illegal;
    state_t     state;

    modport master (
        input  op, funct3, funct7b5, zero, neg, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_write,
               illegal, state
    );

    modport slave (
        output op, funct3, funct7b5, zero, neg, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_write,
               illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: maps the controller's ALU op class and the
// instruction funct fields onto the datapath ALU control code.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [2:0] alu_control
);

    always_comb begin
        // NOTE: every path assigns alu_control via this default, so no latch is inferred.
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    3'b100:  alu_control = ALU_XOR;
                    3'b010:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the RV32I multi-cycle core. Moore outputs are registered
// alongside the state; pc_write/ir_write/illegal/alu_control also see live inputs.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    state_t     state_q, state_d;
    ctrl_out_t  out_q, out_d;
    logic       taken;
    logic [2:0] alu_control;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR1;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_JAL,
            S_LUI:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JALR1:    state_d = S_JALR2;
            S_JALR2:    state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
        out_d = state_outputs(state_d, bus.op);
    end

    // NOTE: state and registered outputs use non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            out_q   <= state_outputs(RESET_STATE, bus.op);
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        case (bus.funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = !bus.zero;
            3'b100:  taken = bus.neg;
            3'b101:  taken = !bus.neg;
            default: taken = 1'b0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (out_q.alu_op),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .is_rtype    (out_q.is_rtype),
        .alu_control (alu_control)
    );

    // Reset masks every output combinationally, including the cycle reset is first seen.
    assign bus.pc_write    = rst_n & (out_q.pc_write
                                      | (out_q.fetch  & bus.mem_ready)
                                      | (out_q.branch & taken));
    assign bus.ir_write    = rst_n & out_q.fetch & bus.mem_ready;
    assign bus.adr_src     = rst_n & out_q.adr_src;
    assign bus.mem_write   = rst_n & out_q.mem_write;
    assign bus.reg_write   = rst_n & out_q.reg_write;
    assign bus.illegal     = rst_n & (state_q == S_DECODE) & !is_legal_op(bus.op);
    assign bus.result_src  = {2{rst_n}} & out_q.result_src;
    assign bus.alu_src_a   = {2{rst_n}} & out_q.alu_src_a;
    assign bus.alu_src_b   = {2{rst_n}} & out_q.alu_src_b;
    assign bus.imm_src     = {3{rst_n}} & out_q.imm_src;
    assign bus.alu_control = {3{rst_n}} & alu_control;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected outputs are queued
// as each instruction is issued and popped/compared once per cycle.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pcw, irw, mw, rw, ill, adr;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu, imm;
    } obs_t;

    typedef struct packed {
        state_t st;
        obs_t   o;
    } exp_t;

    localparam obs_t ZERO = '0;

    exp_t  sb_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    string tag   = "init";

    function automatic obs_t mk(input logic pcw, irw, mw, rw, ill, adr,
                                input logic [1:0] rs, sa, sb,
                                input logic [2:0] alu, imm);
        obs_t o;
        o.pcw = pcw; o.irw = irw; o.mw = mw; o.rw = rw; o.ill = ill; o.adr = adr;
        o.rs = rs; o.sa = sa; o.sb = sb; o.alu = alu; o.imm = imm;
        return o;
    endfunction

    task automatic push(input state_t st, input obs_t o);
        exp_t e;
        e.st = st;
        e.o  = o;
        sb_q.push_back(e);
    endtask

    task automatic push_fetch(input logic mr);
        push(S_FETCH, mk(mr, mr, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000));
    endtask

    task automatic push_decode(input logic ill);
        push(S_DECODE, mk(0, 0, 0, 0, ill, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010));
    endtask

    task automatic push_aluwb();
        push(S_ALUWB, mk(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input string name);
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
        tag = name; cyc = 0;
    endtask

    // One clock: drive inputs, sample at the falling edge, compare the queued expectation.
    task automatic step(input logic mr, input logic z, input logic n);
        exp_t e;
        obs_t got;
        bus.mem_ready = mr; bus.zero = z; bus.neg = n;
        @(negedge clk);
        got = mk(bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.illegal,
                 bus.adr_src, bus.result_src, bus.alu_src_a, bus.alu_src_b,
                 bus.alu_control, bus.imm_src);
        total++;
        assert (sb_q.size() != 0) else begin
            bad++;
            $error("FAIL %s c%0d empty: got=%0d queued, required>0", tag, cyc, sb_q.size());
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            total++;
            assert (got === e.o) else begin
                bad++;
                $error("FAIL %s c%0d outputs: got=%h required=%h", tag, cyc, got, e.o);
            end
            total++;
            assert (bus.state === e.st) else begin
                bad++;
                $error("FAIL %s c%0d state: got=%s required=%s", tag, cyc,
                       bus.state.name(), e.st.name());
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [2:0] exp_alu, input string name);
        set_instr(op, f3, f7, name);
        push_fetch(1);
        push_decode(0);
        if (op == OP_RTYPE)
            push(S_EXECR, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, exp_alu, 3'b000));
        else
            push(S_EXECI, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, exp_alu, 3'b000));
        push_aluwb();
        repeat (4) step(1, 0, 0);
    endtask

    task automatic run_branch(input logic [2:0] f3, input logic z, input logic n,
                              input logic exp_taken, input string name);
        set_instr(OP_BRANCH, f3, 0, name);
        push_fetch(1);
        push_decode(0);
        push(S_BRANCH, mk(exp_taken, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000));
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, z, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
        bus.zero = 1'b0; bus.neg = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Held reset: everything zero even with mem_ready high in FETCH.
        tag = "reset_hold"; cyc = 0;
        push(S_FETCH, ZERO);
        step(1, 0, 0);
        rst_n = 1'b1;

        // add interrupted by a 2-cycle reset in EXECR, then re-run to completion.
        set_instr(OP_RTYPE, 3'b000, 0, "add_rst");
        push_fetch(1); step(1, 0, 0);
        push_decode(0); step(1, 0, 0);
        rst_n = 1'b0;
        push(S_EXECR, ZERO); step(1, 0, 0);
        push(S_FETCH, ZERO); step(1, 0, 0);
        rst_n = 1'b1;
        push_fetch(1); step(1, 0, 0);
        push_decode(0); step(1, 0, 0);
        push(S_EXECR, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000));
        step(1, 0, 0);
        push_aluwb(); step(1, 0, 0);

        // ALU decode across R and I forms.
        run_alu(OP_RTYPE, 3'b000, 1, 3'b001, "sub");
        run_alu(OP_ITYPE, 3'b000, 1, 3'b000, "addi_f7b5");
        run_alu(OP_RTYPE, 3'b111, 0, 3'b010, "and");
        run_alu(OP_RTYPE, 3'b110, 0, 3'b011, "or");
        run_alu(OP_ITYPE, 3'b100, 0, 3'b100, "xori");
        run_alu(OP_ITYPE, 3'b010, 0, 3'b101, "slti");

        // lw with a fetch wait and two MEMREAD wait cycles.
        set_instr(OP_LOAD, 3'b010, 0, "lw");
        push_fetch(0); step(0, 0, 0);
        push_fetch(1); step(1, 0, 0);
        push_decode(0); step(1, 0, 0);
        push(S_MEMADR, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000));
        step(1, 0, 0);
        repeat (3) push(S_MEMREAD, mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
        step(0, 0, 0); step(0, 0, 0); step(1, 0, 0);
        push(S_MEMWB, mk(0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000));
        step(1, 0, 0);

        // sw with one MEMWRITE wait cycle.
        set_instr(OP_STORE, 3'b010, 0, "sw");
        push_fetch(1); step(1, 0, 0);
        push_decode(0); step(1, 0, 0);
        push(S_MEMADR, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001));
        step(1, 0, 0);
        repeat (2) push(S_MEMWRITE, mk(0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
        step(0, 0, 0); step(1, 0, 0);

        // Branch conditions, including an unsupported funct3.
        run_branch(3'b000, 1, 0, 1, "beq_z1");
        run_branch(3'b001, 1, 0, 0, "bne_z1");
        run_branch(3'b001, 0, 0, 1, "bne_z0");
        run_branch(3'b100, 0, 1, 1, "blt_n1");
        run_branch(3'b101, 0, 1, 0, "bge_n1");
        run_branch(3'b010, 1, 1, 0, "bf3_010");

        // jal
        set_instr(OP_JAL, 3'b000, 0, "jal");
        push_fetch(1); step(1, 0, 0);
        push_decode(0); step(1, 0, 0);
        push(S_JAL, mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011));
        step(1, 0, 0);
        push_aluwb(); step(1, 0, 0);

        // lui
        set_instr(OP_LUI, 3'b101, 1, "lui");
        push_fetch(1); step(1, 0, 0);
        push_decode(0); step(1, 0, 0);
        push(S_LUI, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b100));
        step(1, 0, 0);
        push_aluwb(); step(1, 0, 0);

        // jalr
        set_instr(OP_JALR, 3'b000, 0, "jalr");
        push_fetch(1); step(1, 0, 0);
        push_decode(0); step(1, 0, 0);
        push(S_JALR1, mk(0, 0, 0, 1, 0, 0, 2'b11, 2'b10, 2'b01, 3'b000, 3'b000));
        step(1, 0, 0);
        push(S_JALR2, mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
        step(1, 0, 0);

        // Unsupported opcode: one illegal pulse in DECODE, then straight back to FETCH.
        set_instr(7'b0000000, 3'b000, 0, "illegal");
        push_fetch(1); step(1, 0, 0);
        push_decode(1); step(1, 0, 0);
        push_fetch(0); step(0, 0, 0);
        push_fetch(0); step(0, 0, 0);

        tag = "drain"; cyc = 0;
        total++;
        assert (sb_q.size() == 0) else begin
            bad++;
            $error("FAIL drain: got=%0d leftover, required=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
